// File: rtl/signmag_alu_seq.sv
// Sign-magnitude add/sub/mul unit with a start/done handshake and registered result and flags.
// Add/sub finishes in 2 cycles and mul in WIDTH cycles; start is only accepted while idle.
module signmag_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 cf,
    output logic                 ovf,
    output logic                 sf,
    output logic                 zf
);

    localparam int MW = WIDTH - 1;
    localparam int PW = 2 * WIDTH - 2;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_ADDSUB, S_MUL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      acc_q, acc_d, mcand_q, mcand_d;
    logic [MW-1:0]      mplier_q, mplier_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               cf_q, cf_d, ovf_q, ovf_d, sf_q, sf_d, zf_q, zf_d;

    // Both zeros (+0 and -0) map to all-zeros in two's complement.
    function automatic logic [WIDTH-1:0] to_tc(input logic [WIDTH-1:0] v);
        if (v[WIDTH-2:0] == '0)
            return '0;
        else if (v[WIDTH-1])
            return -{1'b0, v[WIDTH-2:0]};
        else
            return v;
    endfunction

    logic             is_sub;
    logic [WIDTH-1:0] at, bt, bt_eff, low, neg_low, sm;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    acc_next;
    logic             msign;

    assign is_sub  = (op_q == 2'b01);
    assign at      = to_tc(a_q);
    assign bt      = to_tc(b_q);
    assign bt_eff  = is_sub ? -bt : bt;
    assign sum     = {1'b0, at} + {1'b0, bt_eff};
    assign low     = sum[WIDTH-1:0];
    assign neg_low = -low;
    // The most-negative sum negates to itself, leaving sign=1 with magnitude 0.
    assign sm      = (low == '0) ? '0 :
                     low[WIDTH-1] ? {1'b1, neg_low[WIDTH-2:0]} : low;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign msign    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) && (acc_next != '0);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        cf_d     = cf_q;
        ovf_d    = ovf_q;
        sf_d     = sf_q;
        zf_d     = zf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d  = a;
                    b_d  = b;
                    op_d = op;
                    if (op == 2'b10) begin
                        state_d  = S_MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{(PW-MW){1'b0}}, a[WIDTH-2:0]};
                        mplier_d = b[WIDTH-2:0];
                    end else begin
                        state_d = S_ADDSUB;
                    end
                end
            end
            S_ADDSUB: begin
                result_d = {{WIDTH{1'b0}}, sm};
                cf_d     = sum[WIDTH] ^ is_sub;
                ovf_d    = (at[WIDTH-1] == bt_eff[WIDTH-1]) && (sum[WIDTH-1] != at[WIDTH-1]);
                sf_d     = sm[WIDTH-1];
                zf_d     = (sm == '0);
                state_d  = S_DONE;
            end
            S_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 2)) begin
                    result_d = {msign, 1'b0, acc_next};
                    cf_d     = 1'b0;
                    ovf_d    = 1'b0;
                    sf_d     = msign;
                    zf_d     = (acc_next == '0);
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            cf_q     <= 1'b0;
            ovf_q    <= 1'b0;
            sf_q     <= 1'b0;
            zf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            cf_q     <= cf_d;
            ovf_q    <= ovf_d;
            sf_q     <= sf_d;
            zf_q     <= zf_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cf     = cf_q;
    assign ovf    = ovf_q;
    assign sf     = sf_q;
    assign zf     = zf_q;

endmodule

// File: tb/tb_signmag_alu_seq.sv
// Bench for signmag_alu_seq: WIDTH=8 and WIDTH=16 instances checked against an arithmetic model.
module tb_signmag_alu_seq;

    logic        clk, rst_n;
    logic        st8, st16;
    logic [1:0]  op8, op16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        busy8, done8, cf8, ovf8, sf8, zf8;
    logic        busy16, done16, cf16, ovf16, sf16, zf16;
    logic [15:0] res8;
    logic [31:0] res16;

    int tests_run = 0;
    int fails = 0;

    signmag_alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8),
        .cf(cf8), .ovf(ovf8), .sf(sf8), .zf(zf8)
    );

    signmag_alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(res16),
        .cf(cf16), .ovf(ovf16), .sf(sf16), .zf(zf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation packing: {result[31:0], cf, ovf, sf, zf}
    function automatic logic [35:0] get_obs(input int w);
        if (w == 16) return {res16, cf16, ovf16, sf16, zf16};
        return {16'h0, res8, cf8, ovf8, sf8, zf8};
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 16) ? busy16 : busy8;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 16) ? done16 : done8;
    endfunction

    // Reference: decode to signed integers, do the arithmetic, re-encode.
    function automatic logic [35:0] model(input int w, input logic [1:0] o,
                                          input logic [15:0] av, input logic [15:0] bv);
        longint half, full, ma, mb, sa, sb, va, vb, vb2, s, pa, pb, r, res, mag;
        logic cf, ovf, sf, zf;
        half = longint'(1) << (w - 1);
        full = half << 1;
        ma = longint'(av) & (half - 1);
        mb = longint'(bv) & (half - 1);
        sa = (longint'(av) >> (w - 1)) & 1;
        sb = (longint'(bv) >> (w - 1)) & 1;
        va = (sa != 0) ? -ma : ma;
        vb = (sb != 0) ? -mb : mb;
        if (o == 2'b10) begin
            mag = ma * mb;
            sf  = (sa != sb) && (mag != 0);
            res = mag + (sf ? (longint'(1) << (2 * w - 1)) : 0);
            cf  = 1'b0;
            ovf = 1'b0;
            zf  = (mag == 0);
        end else begin
            vb2 = (o == 2'b01) ? -vb : vb;
            s   = va + vb2;
            pa  = (va < 0) ? va + full : va;
            pb  = (vb2 < 0) ? vb2 + full : vb2;
            cf  = ((pa + pb) >= full) ^ (o == 2'b01);
            ovf = (s >= half) || (s < -half);
            r   = s;
            if (r >= half) r = r - full;
            if (r < -half) r = r + full;
            res = (r == 0) ? 0 : (r < 0) ? half + ((-r) % half) : r;
            sf  = (res >= half);
            zf  = (res == 0);
        end
        return {res[31:0], cf, ovf, sf, zf};
    endfunction

    task automatic drive(input int w, input logic s, input logic [1:0] o,
                         input logic [15:0] av, input logic [15:0] bv);
        if (w == 16) begin
            st16 = s; op16 = o; a16 = av; b16 = bv;
        end else begin
            st8 = s; op8 = o; a8 = av[7:0]; b8 = bv[7:0];
        end
    endtask

    // Issues one operation; burst keeps start high with random junk inputs while busy.
    task automatic run_op(input int w, input logic [1:0] o, input logic [15:0] av,
                          input logic [15:0] bv, input bit burst,
                          output logic [35:0] obs, output int lat, output bit hs_ok);
        bit seen;
        seen  = 0;
        lat   = 0;
        hs_ok = 1;
        obs   = '0;
        @(negedge clk);
        drive(w, 1'b1, o, av, bv);
        for (int n = 1; n <= 100 && !seen; n++) begin
            @(negedge clk);
            if (burst) drive(w, 1'b1, 2'($urandom), 16'($urandom), 16'($urandom));
            else       drive(w, 1'b0, o, av, bv);
            if (get_busy(w) !== 1'b1) hs_ok = 0;
            if (get_done(w) === 1'b1) begin
                seen = 1;
                lat  = n;
                obs  = get_obs(w);
            end
        end
        @(negedge clk);
        drive(w, 1'b0, o, av, bv);
        if (get_done(w) !== 1'b0 || get_busy(w) !== 1'b0 || get_obs(w) !== obs) hs_ok = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(8, 1'b0, 2'b00, 16'h0, 16'h0);
        drive(16, 1'b0, 2'b00, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy8, done8, busy16, done16} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_busy_done got=%b want=0000", {busy8, done8, busy16, done16});
        end
        tests_run++;
        if (get_obs(8) !== 36'h0) begin
            fails++;
            $display("FAIL reset_obs8 got=%h want=0", get_obs(8));
        end
        tests_run++;
        if (get_obs(16) !== 36'h0) begin
            fails++;
            $display("FAIL reset_obs16 got=%h want=0", get_obs(16));
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops  [7] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
        logic [7:0]  av   [7] = '{8'h40, 8'h05, 8'h05, 8'h85, 8'h7F, 8'h80, 8'h80};
        logic [7:0]  bv   [7] = '{8'h40, 8'h83, 8'h83, 8'h07, 8'hFF, 8'h85, 8'h00};
        logic [15:0] rexp [7] = '{16'h0080, 16'h0002, 16'h0008, 16'h8023, 16'hBF01, 16'h0000, 16'h0000};
        logic [3:0]  fexp [7] = '{4'b0110, 4'b1000, 4'b1000, 4'b0010, 4'b0010, 4'b0001, 4'b1001};
        logic [35:0] obs;
        int lat;
        bit hs;
        for (int i = 0; i < 7; i++) begin
            run_op(8, ops[i], {8'h0, av[i]}, {8'h0, bv[i]}, 1'b0, obs, lat, hs);
            tests_run++;
            if (obs !== {16'h0, rexp[i], fexp[i]}) begin
                fails++;
                $display("FAIL directed_%0d got=%h want=%h", i, obs, {16'h0, rexp[i], fexp[i]});
            end
            tests_run++;
            if (lat !== ((ops[i] == 2'b10) ? 8 : 2) || !hs) begin
                fails++;
                $display("FAIL directed_lat_%0d got=%0d hs=%0d want=%0d", i, lat, hs,
                         (ops[i] == 2'b10) ? 8 : 2);
            end
        end
    endtask

    task automatic test_random();
        logic [35:0] obs, exp;
        logic [15:0] av, bv;
        logic [1:0]  o;
        int lat, w;
        bit hs;
        for (int i = 0; i < 40; i++) begin
            w  = (i % 2 == 0) ? 8 : 16;
            av = 16'($urandom);
            bv = 16'($urandom);
            if (w == 8) begin
                av[15:8] = 8'h0;
                bv[15:8] = 8'h0;
            end
            if ($urandom_range(0, 5) == 0) av = av & ((w == 8) ? 16'h0080 : 16'h8000);
            o   = 2'($urandom);
            exp = model(w, o, av, bv);
            run_op(w, o, av, bv, 1'b0, obs, lat, hs);
            tests_run++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL random_%0d w=%0d op=%0d a=%h b=%h got=%h want=%h",
                         i, w, o, av, bv, obs, exp);
            end
            tests_run++;
            if (lat !== ((o == 2'b10) ? w : 2) || !hs) begin
                fails++;
                $display("FAIL random_lat_%0d got=%0d hs=%0d want=%0d", i, lat, hs,
                         (o == 2'b10) ? w : 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] obs;
        int lat;
        bit hs;
        run_op(8, 2'b10, 16'h0085, 16'h0007, 1'b1, obs, lat, hs);
        tests_run++;
        if (obs !== model(8, 2'b10, 16'h0085, 16'h0007) || lat !== 8 || !hs) begin
            fails++;
            $display("FAIL burst_mul got=%h lat=%0d hs=%0d want=%h lat=8",
                     obs, lat, hs, model(8, 2'b10, 16'h0085, 16'h0007));
        end
        run_op(8, 2'b01, 16'h0003, 16'h0009, 1'b0, obs, lat, hs);
        tests_run++;
        if (obs !== model(8, 2'b01, 16'h0003, 16'h0009) || lat !== 2 || !hs) begin
            fails++;
            $display("FAIL burst_next got=%h lat=%0d hs=%0d want=%h lat=2",
                     obs, lat, hs, model(8, 2'b01, 16'h0003, 16'h0009));
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [35:0] obs;
        int lat, stray;
        bit hs;
        run_op(8, 2'b00, 16'h0005, 16'h0003, 1'b0, obs, lat, hs);
        @(negedge clk);
        drive(8, 1'b1, 2'b10, 16'h0085, 16'h0007);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            drive(8, 1'b0, 2'b10, 16'h0085, 16'h0007);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests_run++;
        if ({busy8, done8} !== 2'b00 || get_obs(8) !== 36'h0) begin
            fails++;
            $display("FAIL reset_mid_mul busy=%b done=%b obs=%h want all 0", busy8, done8, get_obs(8));
        end
        stray = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) stray++;
        end
        tests_run++;
        if (stray != 0) begin
            fails++;
            $display("FAIL reset_no_done got=%0d active cycles want=0", stray);
        end
    endtask

    task automatic test_wide();
        logic [35:0] obs;
        int lat;
        bit hs;
        run_op(16, 2'b10, 16'h8005, 16'h0007, 1'b0, obs, lat, hs);
        tests_run++;
        if (obs !== {32'h80000023, 4'b0010} || lat !== 16 || !hs) begin
            fails++;
            $display("FAIL wide_mul got=%h lat=%0d hs=%0d want=%h lat=16",
                     obs, lat, hs, {32'h80000023, 4'b0010});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_mul();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/signmag_alu_seq.md
Name: signmag_alu_seq

Overview:
Multi-cycle sign-magnitude arithmetic unit and the successor to the team's combinational 8-bit add/sub block. It is parametrised in WIDTH and adds a shift-add multiply mode, a start/done handshake and registered results and flags. It sits between operand registers and the result bus of the experiment datapath, and accepts one operation at a time.

Parameters:
WIDTH, 8, operand width in bits; operands are sign-magnitude with MSB = sign and magnitude in [WIDTH-2:0]; legal range 4..32.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
start  input  1  request a new operation; sampled only in IDLE
op  input  2  00 add, 01 sub (a-b), 10 mul, 11 reserved (executes as add)
a  input  WIDTH  operand A, sign-magnitude
b  input  WIDTH  operand B, sign-magnitude
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when result and flags update
result  output  2*WIDTH  add/sub: {WIDTH zeros, sum}; mul: sign-magnitude product, sign at bit 2W-1
cf  output  1  add: carry out; sub: inverted carry (borrow); mul: 0
ovf  output  1  signed overflow (add/sub); mul: 0
sf  output  1  sign bit of the sign-magnitude result
zf  output  1  result magnitude and sign both zero

Behaviour:
- Reset: when rst_n=0 at an edge the FSM goes to IDLE and busy, done, result, cf, ovf, sf and zf all become 0. This holds mid-operation: the in-flight operation is abandoned and produces no done pulse.
- States: IDLE, ADDSUB, MUL, DONE.
- IDLE with start=1 at edge k: latch a, b and op. op != 10 goes to ADDSUB; op=10 goes to MUL with the iteration counter cleared.
- IDLE with start=0: stay in IDLE.
- start is ignored in every state except IDLE; operand or op changes while busy have no effect.
- Operand conversion to two's complement: magnitude 0 (+0 or -0) converts to all-zeros. A negative value converts to {1, ~mag+1}. A positive value passes through unchanged.
- ADDSUB (one cycle):
  - For sub, negate b's two's-complement form (~b+1).
  - Form the WIDTH+1-bit sum.
  - cf = carry bit, inverted when op is sub.
  - ovf = operand sign bits equal and sum sign differs from them.
  - The WIDTH-bit wrapped sum converts back to sign-magnitude: zero gives 0; negative gives {1, ~low+1}.
  - The most-negative pattern 1000..0 converts to result 1000..0, with sf=1 and zf=0.
  - sf = result MSB; zf = (result == 0).
  - Next state is DONE.
- MUL:
  - Unsigned shift-add of the WIDTH-1-bit magnitudes into a 2W-2-bit accumulator, one multiplier bit per cycle, LSB first.
  - Exactly WIDTH-1 cycles (edges k+1 .. k+W-1), then DONE.
  - Product sign = a[W-1] XOR b[W-1], forced to 0 when the magnitude is 0.
  - result = {sign, 1'b0, magnitude[2W-3:0]}; bit 2W-2 is always 0.
  - cf = 0, ovf = 0, sf = sign, zf = (magnitude == 0).
- DONE (one cycle): done=1 and busy=1; result and flags become valid at this cycle's outputs. Next state is IDLE unconditionally; start in this cycle is ignored.
- Latency from the start edge to done high: add/sub 2 cycles (ADDSUB then DONE); mul WIDTH cycles.
- Minimum interval between accepted starts: add/sub 3 cycles; mul WIDTH+1 cycles.
- result and flags are registered and hold their values until the next DONE or reset; they do not change while busy.

Test Plan:
- Overflow add, WIDTH=8: a=0x40, b=0x40, op=00 -> done 2 cycles after start; result=0x0080, cf=0, ovf=1, sf=1, zf=0.
- Mixed-sign add then sub: a=0x05, b=0x83. op=00 -> result=0x0002, cf=1, ovf=0, sf=0, zf=0. op=01 -> result=0x0008, cf=1, ovf=0.
- Signed multiply: a=0x85 (-5), b=0x07 -> done exactly 8 cycles after start; result=0x8023, sf=1, cf=0, ovf=0, zf=0. Max magnitude: a=0x7F, b=0xFF -> result=0xBF01.
- Negative-zero handling: a=0x80 (-0), b=0x85, op=10 -> result=0x0000, sf=0, zf=1. a=0x80, b=0x00, op=01 -> result=0x0000, zf=1.
- Handshake: pulse start every cycle during a mul -> only the first is accepted; busy stays 1 until after DONE; exactly one done pulse; the next start is accepted in IDLE.
- Reset mid-mul: drop rst_n on the 4th MUL cycle -> next edge: busy=0, done=0, result=0, all flags 0; no done pulse. WIDTH=16 rerun of the multiply case: 0x8005 x 0x0007 -> 0x80000023 after 16 cycles.
